// File: rtl/lsu_mem_sequencer.sv
// RV32 load/store sequencer onto a byte-banked data port (sw/sb/lw/lbu).
// Define MISALIGN_SPLIT_EN to split misaligned h/w accesses into byte ops.
module lsu_mem_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_sw,
   output logic        mem_sb,
   output logic        mem_lw,
   output logic        mem_lbu,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t      state;
   logic        store_q;
   logic        word_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] buf_q;
   logic [1:0]  idx_q;
   logic [1:0]  last_q;

   logic        illegal;
   logic        misal;
   logic        req_err;
   logic        req_word;
   logic [1:0]  req_last;

   logic        busy_op;
   logic        last_op;
   logic [31:0] op_addr;
   logic [7:0]  st_byte;
   logic [31:0] merged;
   logic [31:0] ext_data;

   assign req_ready = (state == IDLE) && !rst;

   always_comb begin
      illegal  = 1'b0;
      misal    = 1'b0;
      req_last = 2'd0;
      req_word = 1'b0;
      unique case (req_funct3)
         3'b000, 3'b001, 3'b010: illegal = 1'b0;
         3'b100, 3'b101:         illegal = req_store;
         default:                illegal = 1'b1;
      endcase
      // memory has no halfword strobe, so every h/hu is two byte ops
      unique case (req_funct3[1:0])
         2'b01: begin
            misal    = req_addr[0];
            req_last = 2'd1;
         end
         2'b10: begin
            misal    = |req_addr[1:0];
            req_last = misal ? 2'd3 : 2'd0;
            req_word = !misal;
         end
         default: ;
      endcase
`ifdef MISALIGN_SPLIT_EN
      req_err = illegal;
`else
      req_err = illegal || misal;
`endif
   end

   assign busy_op = (state == BUSY) && !rst;
   assign last_op = idx_q == last_q;
   assign op_addr = addr_q + {30'd0, idx_q};
   assign st_byte = wdata_q[{idx_q, 3'b000} +: 8];

   assign mem_sw  = busy_op && store_q && word_q;
   assign mem_sb  = busy_op && store_q && !word_q;
   assign mem_lw  = busy_op && !store_q && word_q;
   assign mem_lbu = busy_op && !store_q && !word_q;

   assign mem_addr  = busy_op ? op_addr : 32'd0;
   assign mem_wdata = !(busy_op && store_q) ? 32'd0 :
                      word_q ? wdata_q : {24'd0, st_byte};

   always_comb begin
      merged = buf_q;
      if (word_q)
         merged = mem_rdata;
      else
         merged[{idx_q, 3'b000} +: 8] = mem_rdata[7:0];
      ext_data = merged;
      unique case (f3_q[1:0])
         2'b00: ext_data = {{24{merged[7] & ~f3_q[2]}}, merged[7:0]};
         2'b01: ext_data = {{16{merged[15] & ~f3_q[2]}}, merged[15:0]};
         default: ext_data = merged;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'd0;
         store_q    <= 1'b0;
         word_q     <= 1'b0;
         f3_q       <= 3'd0;
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         buf_q      <= 32'd0;
         idx_q      <= 2'd0;
         last_q     <= 2'd0;
      end else begin
         unique case (state)
            IDLE: begin
               resp_valid <= 1'b0;
               if (req_valid) begin
                  store_q <= req_store;
                  f3_q    <= req_funct3;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  word_q  <= req_word;
                  last_q  <= req_last;
                  idx_q   <= 2'd0;
                  buf_q   <= 32'd0;
                  if (req_err) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'd0;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (!store_q)
                  buf_q <= merged;
               if (last_op) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= store_q ? 32'd0 : ext_data;
               end else begin
                  idx_q <= idx_q + 2'd1;
               end
            end
            RESP: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               idx_q      <= 2'd0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
